uart_alu_sequencer: RTL and testbench

//  Multi-byte successor to the byte-wide UART-to-ALU interface. Sits between the UART RX/TX

---
 rtl/uart_alu_sequencer.sv | 155 +++++++++++++++
 tb/tb_uart_alu_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_alu_sequencer.sv
// Frames UART RX bytes into ALU operands A/B plus an opcode, commits them to the ALU,
// and streams the ALU result back to the TX core MSB byte first, with inter-byte timeout.
module uart_alu_sequencer #(
  parameter int unsigned NB_BYTE     = 8,
  parameter int unsigned NB_DATA     = 16,
  parameter int unsigned NB_OP       = 6,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_rx_valid,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic [NB_DATA-1:0] i_result,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_operation,
  output logic               o_tx_start,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_busy,
  output logic               o_error
);

  localparam int unsigned BYTES = NB_DATA / NB_BYTE;
  localparam int unsigned CNT_W = $clog2(BYTES + 1);
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    RX_A    = 3'd0,
    RX_B    = 3'd1,
    RX_OP   = 3'd2,
    LATCH   = 3'd3,
    TX_SEND = 3'd4,
    TX_WAIT = 3'd5
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [TMR_W-1:0]   timer_q;
  logic [NB_DATA-1:0] sh_a_q;
  logic [NB_DATA-1:0] sh_b_q;
  logic [NB_DATA-1:0] tx_sh_q;

  logic op_legal_c;
  logic partial_c;
  logic expire_c;

  // Opcode byte must have clean upper bits and name one of the supported ALU functions.
  always_comb begin
    op_legal_c = 1'b0;
    if (i_rx_data[NB_BYTE-1:NB_OP] == '0) begin
      case (i_rx_data[NB_OP-1:0])
        NB_OP'('h20), NB_OP'('h22), NB_OP'('h24), NB_OP'('h25),
        NB_OP'('h26), NB_OP'('h27), NB_OP'('h03), NB_OP'('h02): op_legal_c = 1'b1;
        default: op_legal_c = 1'b0;
      endcase
    end
  end

  assign partial_c = ((state_q == RX_A) && (cnt_q != '0)) || (state_q == RX_B) || (state_q == RX_OP);
  assign expire_c  = partial_c && !i_rx_valid && (timer_q == TMR_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= RX_A;
      cnt_q       <= '0;
      timer_q     <= '0;
      sh_a_q      <= '0;
      sh_b_q      <= '0;
      tx_sh_q     <= '0;
      o_data_a    <= '0;
      o_data_b    <= '0;
      o_operation <= '0;
      o_tx_start  <= 1'b0;
      o_tx_data   <= '0;
      o_busy      <= 1'b0;
      o_error     <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      o_error    <= 1'b0;
      case (state_q)
        RX_A, RX_B, RX_OP: begin
          if (i_rx_valid) begin
            timer_q <= '0;
            if (state_q == RX_A) begin
              sh_a_q <= NB_DATA'({sh_a_q, i_rx_data});
              if (cnt_q == CNT_W'(BYTES - 1)) begin
                cnt_q   <= '0;
                state_q <= RX_B;
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end else if (state_q == RX_B) begin
              sh_b_q <= NB_DATA'({sh_b_q, i_rx_data});
              if (cnt_q == CNT_W'(BYTES - 1)) begin
                cnt_q   <= '0;
                state_q <= RX_OP;
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end else begin
              // Shadows are consumed either way; the next frame starts clean.
              sh_a_q <= '0;
              sh_b_q <= '0;
              if (op_legal_c) begin
                o_data_a    <= sh_a_q;
                o_data_b    <= sh_b_q;
                o_operation <= i_rx_data[NB_OP-1:0];
                o_busy      <= 1'b1;
                state_q     <= LATCH;
              end else begin
                o_error <= 1'b1;
                state_q <= RX_A;
              end
            end
          end else if (expire_c) begin
            o_error <= 1'b1;
            state_q <= RX_A;
            cnt_q   <= '0;
            timer_q <= '0;
            sh_a_q  <= '0;
            sh_b_q  <= '0;
          end else if (partial_c) begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        LATCH: begin
          tx_sh_q <= i_result;
          cnt_q   <= CNT_W'(BYTES);
          state_q <= TX_SEND;
        end
        TX_SEND: begin
          o_tx_start <= 1'b1;
          o_tx_data  <= tx_sh_q[NB_DATA-1 -: NB_BYTE];
          state_q    <= TX_WAIT;
        end
        TX_WAIT: begin
          if (i_tx_done) begin
            tx_sh_q <= NB_DATA'({tx_sh_q, {NB_BYTE{1'b0}}});
            if (cnt_q == CNT_W'(1)) begin
              cnt_q   <= '0;
              o_busy  <= 1'b0;
              state_q <= RX_A;
            end else begin
              cnt_q   <= cnt_q - CNT_W'(1);
              state_q <= TX_SEND;
            end
          end
        end
        default: state_q <= RX_A;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Self-checking bench for uart_alu_sequencer: directed table, timeout/drop/reset sequences,
// and randomized frames against an arithmetic reference model.
module tb_uart_alu_sequencer;

  localparam int unsigned NB_BYTE = 8;
  localparam int unsigned NB_DATA = 16;
  localparam int unsigned NB_OP   = 6;
  localparam int unsigned TO      = 64;
  localparam int unsigned BYTES   = NB_DATA / NB_BYTE;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               rx_valid;
  logic [NB_BYTE-1:0] rx_data;
  logic [NB_DATA-1:0] alu_result;
  logic               tx_done;
  logic [NB_DATA-1:0] data_a;
  logic [NB_DATA-1:0] data_b;
  logic [NB_OP-1:0]   operation;
  logic               tx_start;
  logic [NB_BYTE-1:0] tx_data;
  logic               busy;
  logic               error;

  int checks   = 0;
  int failures = 0;
  int err_seen = 0;
  int err_exp  = 0;
  logic [15:0] cur_a = '0;
  logic [15:0] cur_b = '0;
  logic [5:0]  cur_op = '0;

  always #5 clk = ~clk;

  uart_alu_sequencer #(
    .NB_BYTE(NB_BYTE), .NB_DATA(NB_DATA), .NB_OP(NB_OP), .TIMEOUT_CYC(TO)
  ) dut (
    .i_clock(clk), .i_reset(rst_n), .i_rx_valid(rx_valid), .i_rx_data(rx_data),
    .i_result(alu_result), .i_tx_done(tx_done), .o_data_a(data_a), .o_data_b(data_b),
    .o_operation(operation), .o_tx_start(tx_start), .o_tx_data(tx_data),
    .o_busy(busy), .o_error(error)
  );

  function automatic bit ref_legal(input logic [7:0] op);
    return op inside {8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};
  endfunction

  function automatic logic [15:0] ref_alu(input logic [15:0] a, input logic [15:0] b,
                                          input logic [7:0] op);
    case (op)
      8'h20: return a + b;
      8'h22: return a - b;
      8'h24: return a & b;
      8'h25: return a | b;
      8'h26: return a ^ b;
      8'h27: return ~(a | b);
      8'h03: return 16'($signed(a) >>> b);
      8'h02: return a >> b;
      default: return 16'h0000;
    endcase
  endfunction

  // Combinational ALU the sequencer drives.
  always_comb alu_result = ref_alu(data_a, data_b, {2'b00, operation});

  always @(negedge clk) if (error) err_seen++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] a, input logic [15:0] b, input logic [7:0] op);
    send_byte(a[15:8]); idle($urandom_range(0, 2));
    send_byte(a[7:0]);  idle($urandom_range(0, 2));
    send_byte(b[15:8]); idle($urandom_range(0, 2));
    send_byte(b[7:0]);  idle($urandom_range(0, 2));
    send_byte(op);
  endtask

  // Called at the negedge right after the opcode strobe edge.
  task automatic check_response(input logic [15:0] a, input logic [15:0] b, input logic [7:0] op,
                                input bit exp_err, input logic [15:0] exp_res,
                                input int hold, input bit inject);
    bit seen;
    bit stable;
    logic [7:0] byte_q;
    int n;
    if (exp_err) begin
      err_exp++;
      chk("err_pulse", 32'(error), 32'd1);
      chk("err_keeps_a", 32'(data_a), 32'(cur_a));
      chk("err_keeps_op", 32'(operation), 32'(cur_op));
      idle(1);
      chk("err_one_cycle", 32'(error), 32'd0);
      seen = 1'b0;
      repeat (4) begin
        @(negedge clk);
        seen |= tx_start;
      end
      chk("err_no_tx", 32'(seen), 32'd0);
      chk("err_not_busy", 32'(busy), 32'd0);
      return;
    end
    chk("commit_no_err", 32'(error), 32'd0);
    chk("commit_busy", 32'(busy), 32'd1);
    chk("commit_a", 32'(data_a), 32'(a));
    chk("commit_b", 32'(data_b), 32'(b));
    chk("commit_op", 32'(operation), 32'(op[5:0]));
    cur_a = a; cur_b = b; cur_op = op[5:0];
    idle(1);
    chk("tx_start_early", 32'(tx_start), 32'd0);
    idle(1);
    chk("tx_latency", 32'(tx_start), 32'd1);
    for (int i = 0; i < int'(BYTES); i++) begin
      n = 0;
      while (!tx_start && n < 10) begin
        @(negedge clk);
        n++;
      end
      chk("tx_start_wait", 32'(tx_start), 32'd1);
      byte_q = tx_data;
      chk("tx_byte", 32'(byte_q), 32'(exp_res[15 - 8*i -: 8]));
      stable = 1'b1;
      seen   = 1'b0;
      for (int k = 0; k < hold; k++) begin
        if (inject && k == hold / 2) begin
          rx_valid = 1'b1;
          rx_data  = 8'hAA;
        end
        @(negedge clk);
        rx_valid = 1'b0;
        stable &= (tx_data == byte_q);
        seen   |= tx_start;
      end
      if (hold > 0) begin
        chk("tx_data_stable", 32'(stable), 32'd1);
        chk("tx_start_single", 32'(seen), 32'd0);
        chk("busy_during_tx", 32'(busy), 32'd1);
      end
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
    end
    chk("busy_clear", 32'(busy), 32'd0);
  endtask

  task automatic run_frame(input logic [15:0] a, input logic [15:0] b, input logic [7:0] op,
                           input bit exp_err, input logic [15:0] exp_res,
                           input int hold, input bit inject);
    send_frame(a, b, op);
    check_response(a, b, op, exp_err, exp_res, hold, inject);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  op;
    bit          err;
    logic [15:0] res;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int n;
    int e0;
    logic [15:0] ra, rb;
    logic [7:0]  rop;
    logic [7:0]  ops[8];

    vecs[0]  = '{16'h000F, 16'h0001, 8'h20, 1'b0, 16'h0010};
    vecs[1]  = '{16'h0005, 16'h0002, 8'h3F, 1'b1, 16'h0000};
    vecs[2]  = '{16'h0001, 16'h0001, 8'h20, 1'b0, 16'h0002};
    vecs[3]  = '{16'h002A, 16'h0003, 8'h22, 1'b0, 16'h0027};
    vecs[4]  = '{16'hFFFF, 16'h0001, 8'h20, 1'b0, 16'h0000};
    vecs[5]  = '{16'h00F0, 16'h0FF0, 8'h26, 1'b0, 16'h0F00};
    vecs[6]  = '{16'h0000, 16'h0000, 8'h27, 1'b0, 16'hFFFF};
    vecs[7]  = '{16'h8000, 16'h0004, 8'h02, 1'b0, 16'h0800};
    vecs[8]  = '{16'h8000, 16'h0004, 8'h03, 1'b0, 16'hF800};
    vecs[9]  = '{16'h1234, 16'h00FF, 8'h24, 1'b0, 16'h0034};
    vecs[10] = '{16'h1200, 16'h0034, 8'h25, 1'b0, 16'h1234};
    vecs[11] = '{16'h0001, 16'h0001, 8'h60, 1'b1, 16'h0000};
    ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};

    rst_n = 1'b0; rx_valid = 1'b0; rx_data = '0; tx_done = 1'b0;
    idle(3);
    chk("rst_a", 32'(data_a), 32'd0);
    chk("rst_b", 32'(data_b), 32'd0);
    chk("rst_op", 32'(operation), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    rst_n = 1'b1;
    idle(2);

    foreach (vecs[i])
      run_frame(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].err, vecs[i].res, 3, 1'b0);

    // Partial frame then silence: timeout pulse near TO idle cycles.
    send_byte(8'h12);
    send_byte(8'h34);
    n  = 0;
    e0 = err_seen;
    while (!error && n < int'(TO) + 10) begin
      @(negedge clk);
      n++;
    end
    err_exp++;
    chk("timeout_pulse", 32'(error), 32'd1);
    chk("timeout_not_early", 32'(n >= int'(TO) - 1), 32'd1);
    chk("timeout_not_late", 32'(n <= int'(TO) + 1), 32'd1);
    idle(1);
    chk("timeout_one_cycle", 32'(error), 32'd0);
    run_frame(16'h0004, 16'h0004, 8'h24, 1'b0, 16'h0004, 3, 1'b0);

    // Bytes spaced just under the timeout keep the frame alive.
    e0 = err_seen;
    send_byte(8'h12); idle(int'(TO) - 5);
    send_byte(8'h34); idle(int'(TO) - 5);
    send_byte(8'h00); idle(int'(TO) - 5);
    send_byte(8'h01);
    send_byte(8'h20);
    chk("spaced_no_timeout", 32'(err_seen - e0), 32'd0);
    check_response(16'h1234, 16'h0001, 8'h20, 1'b0, 16'h1235, 2, 1'b0);

    // Slow TX with an RX byte dropped mid-transmission.
    run_frame(16'h0003, 16'h0004, 8'h20, 1'b0, 16'h0007, 100, 1'b1);
    run_frame(16'h0010, 16'h0001, 8'h22, 1'b0, 16'h000F, 2, 1'b0);

    for (int r = 0; r < 20; r++) begin
      ra  = 16'($urandom);
      rb  = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 17)) : 16'($urandom);
      rop = ($urandom_range(0, 4) == 0) ? 8'($urandom) : ops[$urandom_range(0, 7)];
      run_frame(ra, rb, rop, !ref_legal(rop), ref_alu(ra, rb, rop), $urandom_range(0, 5), 1'b0);
    end

    // Asynchronous reset while waiting on the TX core.
    send_frame(16'h0009, 16'h0009, 8'h20);
    idle(5);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_a", 32'(data_a), 32'd0);
    chk("arst_b", 32'(data_b), 32'd0);
    chk("arst_op", 32'(operation), 32'd0);
    chk("arst_tx_data", 32'(tx_data), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_error", 32'(error), 32'd0);
    cur_a = '0; cur_b = '0; cur_op = '0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    run_frame(16'h000F, 16'h0001, 8'h20, 1'b0, 16'h0010, 3, 1'b0);

    idle(2);
    chk("error_pulse_count", 32'(err_seen), 32'(err_exp));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
